// File: rtl/barrett_seq_ctrl_if.sv
// barrett_seq_ctrl_if
//   Operand and result handshake bundle for barrett_seq_ctrl.
//   Ports (signals):
//     in_valid_i  / in_ready_o / x_i        operand handshake (master -> slave)
//     out_valid_o / out_ready_i / result_o  result handshake (slave -> master)
//   modport master : operand producer / result consumer (testbench side)
//   modport slave  : the reduction engine
interface barrett_seq_ctrl_if #(
  parameter int DATA_LENGTH = 64
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [DATA_LENGTH-1:0] x_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [DATA_LENGTH-1:0] result_o;

  modport master (
    output in_valid_i, x_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o
  );

  modport slave (
    input  in_valid_i, x_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o
  );
endinterface

// File: rtl/barrett_seq_ctrl.sv
// barrett_seq_ctrl
//   Sequential Barrett modular reduction: result = x mod m, using one shared
//   full-width multiplier for x*mu and q*m.
//   Ports:
//     clk_i, rst_i                    clock, synchronous active-high reset
//     cfg_we_i, cfg_m_i, cfg_m_bl_i,  configuration write (modulus, its bit
//     cfg_mu_i                        length, precomputed mu)
//     cfg_valid_o, cfg_err_o          legal config loaded / last write rejected
//     bus (slave modport)             operand and result handshakes
//     busy_o                          an operation is in flight
//     done_cnt_o                      wrapping count of consumed results
package multiplier_pkg;
  localparam int DATA_LENGTH = 64;
endpackage

// Plain combinational full-width multiplier.
module bp_multiplier_64x64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);
  assign p_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
endmodule

module barrett_seq_ctrl #(
  parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_we_i,
  input  logic [DATA_LENGTH-1:0] cfg_m_i,
  input  logic [DATA_LENGTH-1:0] cfg_m_bl_i,
  input  logic [DATA_LENGTH-1:0] cfg_mu_i,
  output logic                   cfg_valid_o,
  output logic                   cfg_err_o,
  barrett_seq_ctrl_if.slave      bus,
  output logic                   busy_o,
  output logic [31:0]            done_cnt_o
);
  localparam int DL = DATA_LENGTH;
  localparam int SW = $clog2(2 * DL);
  localparam logic [DL-1:0] DL_LIM = DL'(DL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_XMU = 3'd1,
    MUL_QM  = 3'd2,
    SUB     = 3'd3,
    CORR    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic [DL-1:0]   m_r, m_bl_r, mu_r;
  logic            cfg_valid_r, cfg_err_r;
  // Per-operation snapshot: the in-flight op never sees later config writes.
  logic [DL-1:0]   x_r, mu_w_r, m_w_r, bl_w_r;
  logic [2*DL-1:0] prod_r, prod_s;
  logic [DL-1:0]   r_r, result_r;
  logic [31:0]     done_cnt_r;
  logic [DL-1:0]   q_s, mul_a_s, mul_b_s;
  logic [SW-1:0]   shamt_s;
  logic            accept_s, consume_s;

  bp_multiplier_64x64 #(.WIDTH(DL)) u_mul (
    .a_i (mul_a_s),
    .b_i (mul_b_s),
    .p_o (prod_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and handshake events.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    consume_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid_i && cfg_valid_r) begin
          accept_s = 1'b1;
          state_s  = MUL_XMU;
        end else begin
          state_s = IDLE;
        end
      end
      MUL_XMU: state_s = MUL_QM;
      MUL_QM:  state_s = SUB;
      SUB:     state_s = CORR;
      CORR:    state_s = DONE;
      DONE: begin
        if (bus.out_ready_i) begin
          consume_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Quotient estimate q = (x*mu) >> 2*m_bl; a shift of 2*DL or more leaves 0.
  always_comb begin
    shamt_s = {bl_w_r[SW-2:0], 1'b0};
    if (bl_w_r >= DL_LIM) begin
      q_s = '0;
    end else begin
      q_s = DL'(prod_r >> shamt_s);
    end
  end

  // Multiplier operand select: (q, m) in MUL_QM, (x, mu) otherwise.
  always_comb begin
    if (state_r == MUL_QM) begin
      mul_a_s = q_s;
      mul_b_s = m_w_r;
    end else begin
      mul_a_s = x_r;
      mul_b_s = mu_w_r;
    end
  end

  // Configuration registers; writes only land in IDLE with a nonzero modulus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_r         <= '0;
      m_bl_r      <= '0;
      mu_r        <= '0;
      cfg_valid_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else if (cfg_we_i) begin
      if (state_r != IDLE) begin
        cfg_err_r <= 1'b1;
      end else if (cfg_m_i == '0) begin
        cfg_err_r <= 1'b1;
      end else begin
        m_r         <= cfg_m_i;
        m_bl_r      <= cfg_m_bl_i;
        mu_r        <= cfg_mu_i;
        cfg_valid_r <= 1'b1;
        cfg_err_r   <= 1'b0;
      end
    end else begin
      cfg_err_r <= cfg_err_r;
    end
  end

  // Datapath: operand snapshot, product capture, subtract, correction, count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_r        <= '0;
      mu_w_r     <= '0;
      m_w_r      <= '0;
      bl_w_r     <= '0;
      prod_r     <= '0;
      r_r        <= '0;
      result_r   <= '0;
      done_cnt_r <= 32'd0;
    end else begin
      if (accept_s) begin
        x_r    <= bus.x_i;
        mu_w_r <= mu_r;
        m_w_r  <= m_r;
        bl_w_r <= m_bl_r;
      end
      if ((state_r == MUL_XMU) || (state_r == MUL_QM)) begin
        prod_r <= prod_s;
      end
      if (state_r == SUB) begin
        r_r <= x_r - prod_r[DL-1:0];
      end
      // r is below 2m, so one conditional subtraction completes the reduction.
      if (state_r == CORR) begin
        result_r <= (r_r >= m_w_r) ? (r_r - m_w_r) : r_r;
      end
      if (consume_s) begin
        done_cnt_r <= done_cnt_r + 32'd1;
      end
    end
  end

  assign bus.in_ready_o  = (state_r == IDLE) && cfg_valid_r;
  assign bus.out_valid_o = (state_r == DONE);
  assign bus.result_o    = result_r;
  assign busy_o          = (state_r != IDLE);
  assign cfg_valid_o     = cfg_valid_r;
  assign cfg_err_o       = cfg_err_r;
  assign done_cnt_o      = done_cnt_r;
endmodule

// File: tb/tb_barrett_seq_ctrl.sv
// tb_barrett_seq_ctrl
//   Directed and randomized checks of barrett_seq_ctrl against hand-computed
//   remainders and a modulo reference model.
module tb_barrett_seq_ctrl;
  localparam int DL = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [DL-1:0] cfg_m, cfg_m_bl, cfg_mu;
  logic          cfg_valid, cfg_err, busy;
  logic [31:0]   done_cnt;
  logic [31:0]   exp_cnt;
  int            vectors = 0;
  int            miscompares = 0;

  barrett_seq_ctrl_if #(.DATA_LENGTH(DL)) bus ();

  barrett_seq_ctrl #(.DATA_LENGTH(DL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_m_i     (cfg_m),
    .cfg_m_bl_i  (cfg_m_bl),
    .cfg_mu_i    (cfg_mu),
    .cfg_valid_o (cfg_valid),
    .cfg_err_o   (cfg_err),
    .bus         (bus),
    .busy_o      (busy),
    .done_cnt_o  (done_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (drive at negedge, return at a negedge).
  task automatic cfg_write(input logic [DL-1:0] m, input logic [DL-1:0] bl, input logic [DL-1:0] mu);
    @(negedge clk);
    cfg_we = 1'b1; cfg_m = m; cfg_m_bl = bl; cfg_mu = mu;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Presents x until accepted; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [DL-1:0] x, output bit to);
    int n;
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.x_i = x; n = 0; to = 1'b0;
    while (!bus.in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) to = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat, output bit to);
    lat = 0; to = 1'b0;
    while (!bus.out_valid_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid_o) to = 1'b1;
  endtask

  task automatic consume();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic run_op(input logic [DL-1:0] x, output logic [DL-1:0] res, output int lat, output bit to);
    bit t1, t2;
    lat = 0; t2 = 1'b0;
    issue(x, t1);
    if (!t1) wait_valid(lat, t2);
    res = bus.result_o;
    to = t1 | t2;
    if (!to) consume();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_m = '0; cfg_m_bl = '0; cfg_mu = '0;
    bus.in_valid_i = 1'b0; bus.x_i = '0; bus.out_ready_i = 1'b0;
    exp_cnt = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cfg_valid, cfg_err, bus.out_valid_o, busy, bus.in_ready_o} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000", {cfg_valid, cfg_err, bus.out_valid_o, busy, bus.in_ready_o});
    end
    vectors++;
    if (done_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d expected 0", done_cnt);
    end
    vectors++;
    if (bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_result: got %0d expected 0", bus.result_o);
    end
  endtask

  task automatic test_basic();
    logic [DL-1:0] res; int lat; bit to;
    cfg_write(64'd97, 64'd7, 64'd168);
    vectors++;
    if ({cfg_valid, cfg_err, bus.in_ready_o} !== 3'b101) begin
      miscompares++;
      $display("FAIL cfg_load: got %b expected 101", {cfg_valid, cfg_err, bus.in_ready_o});
    end
    run_op(64'd9000, res, lat, to);
    vectors++;
    if (to || lat !== 4) begin
      miscompares++;
      $display("FAIL latency: got %0d (timeout %0d) expected 4", lat, to);
    end
    vectors++;
    if (res !== 64'd76) begin
      miscompares++;
      $display("FAIL basic_9000: got %0d expected 76", res);
    end
    vectors++;
    if (done_cnt !== 32'd1 || bus.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_cnt: got cnt %0d valid %0d expected cnt 1 valid 0", done_cnt, bus.out_valid_o);
    end
  endtask

  task automatic test_corr();
    logic [DL-1:0] xs [4] = '{64'd96, 64'd97, 64'd0, 64'd9408};
    logic [DL-1:0] es [4] = '{64'd96, 64'd0, 64'd0, 64'd96};
    logic [DL-1:0] res; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], res, lat, to);
      vectors++;
      if (to || res !== es[i]) begin
        miscompares++;
        $display("FAIL corr_x%0d: got %0d expected %0d (timeout %0d)", xs[i], res, es[i], to);
      end
    end
    vectors++;
    if (done_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL corr_cnt: got %0d expected %0d", done_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    issue(64'd9000, to);
    if (!to) wait_valid(lat, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL bp_start: timeout waiting for out_valid");
    end
    bus.in_valid_i = 1'b1; bus.x_i = 64'd5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.out_valid_o, bus.in_ready_o, busy} !== 3'b101 || bus.result_o !== 64'd76) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid/ready/busy %b result %0d expected 101 result 76",
                 c, {bus.out_valid_o, bus.in_ready_o, busy}, bus.result_o);
      end
    end
    bus.in_valid_i = 1'b0;
    consume();
    vectors++;
    if (done_cnt !== exp_cnt || busy !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got cnt %0d busy %0d ready %0d expected cnt %0d busy 0 ready 1",
               done_cnt, busy, bus.in_ready_o, exp_cnt);
    end
  endtask

  task automatic test_cfg_err();
    logic [DL-1:0] res; int lat; bit to;
    cfg_write(64'd0, 64'd0, 64'd0);
    vectors++;
    if ({cfg_valid, cfg_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL cfg_zero_flags: got %b expected 11", {cfg_valid, cfg_err});
    end
    run_op(64'd200, res, lat, to);
    vectors++;
    if (to || res !== 64'd6) begin
      miscompares++;
      $display("FAIL cfg_zero_keep: got %0d expected 6", res);
    end
    cfg_write(64'd97, 64'd7, 64'd168);
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_clear: got %0d expected 0", cfg_err);
    end
  endtask

  task automatic test_cfg_busy();
    logic [DL-1:0] res; int lat; bit to;
    issue(64'd1000, to);
    // Now in MUL_XMU; the next edge enters MUL_QM where the write is presented.
    @(negedge clk);
    cfg_we = 1'b1; cfg_m = 64'd13; cfg_m_bl = 64'd4; cfg_mu = 64'd19;
    @(negedge clk);
    cfg_we = 1'b0;
    if (!to) wait_valid(lat, to);
    vectors++;
    if (to || bus.result_o !== 64'd30) begin
      miscompares++;
      $display("FAIL busy_write_op: got %0d expected 30", bus.result_o);
    end
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_write_err: got %0d expected 1", cfg_err);
    end
    if (!to) consume();
    run_op(64'd1000, res, lat, to);
    vectors++;
    if (to || res !== 64'd30) begin
      miscompares++;
      $display("FAIL busy_write_ignored: got %0d expected 30", res);
    end
  endtask

  task automatic test_same_cycle();
    logic [DL-1:0] res; int lat; bit to;
    cfg_write(64'd97, 64'd7, 64'd168);
    @(negedge clk);
    cfg_we = 1'b1; cfg_m = 64'd13; cfg_m_bl = 64'd4; cfg_mu = 64'd19;
    bus.in_valid_i = 1'b1; bus.x_i = 64'd150;
    @(negedge clk);
    cfg_we = 1'b0; bus.in_valid_i = 1'b0;
    wait_valid(lat, to);
    vectors++;
    if (to || lat !== 4 || bus.result_o !== 64'd53) begin
      miscompares++;
      $display("FAIL same_cycle_old: got %0d lat %0d expected 53 lat 4", bus.result_o, lat);
    end
    if (!to) consume();
    run_op(64'd150, res, lat, to);
    vectors++;
    if (to || res !== 64'd7 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_new: got %0d err %0d expected 7 err 0", res, cfg_err);
    end
  endtask

  task automatic test_reset_midop();
    bit to, seen;
    cfg_write(64'd97, 64'd7, 64'd168);
    issue(64'd9000, to);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (to || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_busy: got %0d expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;
    vectors++;
    if ({cfg_valid, cfg_err, bus.out_valid_o, busy, bus.in_ready_o} !== 5'b00000 ||
        done_cnt !== 32'd0 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL midop_reset: got flags %b cnt %0d result %0d expected 00000 0 0",
               {cfg_valid, cfg_err, bus.out_valid_o, busy, bus.in_ready_o}, done_cnt, bus.result_o);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid_o) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_no_output: got out_valid %0d expected 0", seen);
    end
  endtask

  task automatic test_wrap();
    logic [DL-1:0] res; int lat; bit to;
    cfg_write(64'd97, 64'd7, 64'd168);
    @(negedge clk);
    dut.done_cnt_r = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    run_op(64'd9000, res, lat, to);
    vectors++;
    if (to || done_cnt !== 32'd0 || exp_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL cnt_wrap: got %0d expected 0", done_cnt);
    end
  endtask

  task automatic test_random();
    logic [DL-1:0] m, mu, x, res;
    logic [127:0]  mu_w, msq, xr;
    int            bl, lat;
    bit            to;
    m = 64'd1; msq = 128'd1;
    for (int i = 0; i < 10000; i++) begin
      if (i % 10 == 0) begin
        bl = $urandom_range(63, 2);
        m = {$urandom, $urandom};
        m = m & ((64'd1 << bl) - 64'd1);
        m = m | (64'd1 << (bl - 1));
        mu_w = (128'd1 << (2 * bl)) / {64'd0, m};
        // mu must fit DATA_LENGTH bits; only m = 2^62 breaks that.
        if (mu_w[127:64] != 64'd0) begin
          m = m | 64'd1;
          mu_w = (128'd1 << (2 * bl)) / {64'd0, m};
        end
        mu = mu_w[63:0];
        cfg_write(m, 64'(bl), mu);
        msq = {64'd0, m} * {64'd0, m};
      end
      xr = {64'd0, $urandom, $urandom};
      if (msq <= 128'h1_0000_0000_0000_0000) xr = xr % msq;
      x = xr[63:0];
      run_op(x, res, lat, to);
      vectors++;
      if (to || res !== (x % m)) begin
        miscompares++;
        $display("FAIL random%0d: x %0d m %0d got %0d expected %0d", i, x, m, res, x % m);
      end
    end
    vectors++;
    if (done_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL random_cnt: got %0d expected %0d", done_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corr();
    test_backpressure();
    test_cfg_err();
    test_cfg_busy();
    test_same_cycle();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
